// File: rtl/lht_update_ctrl.sv
// Local history table write sequencer: post-reset zero sweep, then one shift-in update per resolved branch.
// Latency: resolution accept -> update presented on the next cycle; sweep issues one clear per accepted cycle.
// Backpressure: upd_ready_i stalls the output register; a stalled register blocks res_ready_o, a full queue blocks pred_ready_o.
module lht_update_ctrl #(
    parameter int IDX_W = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pred_valid_i,
    input  logic [31:0]              pred_pc_i,
    output logic                     pred_ready_o,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    output logic                     res_ready_o,
    output logic                     res_err_o,
    input  logic                     flush_i,
    output logic                     upd_valid_o,
    output logic [IDX_W-1:0]         upd_idx_o,
    output logic                     upd_taken_o,
    output logic                     upd_clear_o,
    input  logic                     upd_ready_i,
    output logic                     busy_init_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             or_vld_q, or_vld_d;
    logic [IDX_W-1:0] or_idx_q, or_idx_d;
    logic             or_taken_q, or_taken_d;
    logic             res_err_q, res_err_d;

    logic [IDX_W-1:0] mem_q [DEPTH];

    logic run;
    logic push;
    logic pop;
    logic flush_run;

    // Only the low PC bits index the table; the rest are deliberately dropped.
    logic unused_pc_hi;
    assign unused_pc_hi = ^pred_pc_i[31:IDX_W];

    assign run       = (state_q == ST_RUN);
    assign flush_run = flush_i && run;

    // Ready signals look only at registered state, never at same-cycle pops.
    assign pred_ready_o = run && (count_q < CNT_W'(DEPTH));
    assign res_ready_o  = run && (count_q != '0) && (!or_vld_q || upd_ready_i);

    // A flush squashes a same-cycle push; a same-cycle pop still goes ahead.
    assign push = pred_valid_i && pred_ready_o && !flush_i;
    assign pop  = res_valid_i && res_ready_o;

    // During the sweep the update port carries clears of the sweep index.
    assign upd_valid_o = !run || or_vld_q;
    assign upd_clear_o = !run;
    assign upd_idx_o   = run ? or_idx_q : init_idx_q;
    assign upd_taken_o = run && or_taken_q;
    assign busy_init_o = !run;
    assign res_err_o   = res_err_q;
    assign count_o     = count_q;

    // Next-state: sweep sequencing in INIT, queue and output register in RUN.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        or_vld_d   = or_vld_q;
        or_idx_d   = or_idx_q;
        or_taken_d = or_taken_q;
        res_err_d  = run && res_valid_i && (count_q == '0);

        if (!run) begin
            if (upd_ready_i) begin
                if (&init_idx_q) begin
                    state_d = ST_RUN;
                end else begin
                    init_idx_d = init_idx_q + IDX_W'(1);
                end
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end

            if (flush_run) begin
                rd_ptr_d = wr_ptr_q;
                count_d  = '0;
            end else begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end

            // Output register: a new load wins over a drain in the same cycle.
            if (pop) begin
                or_vld_d   = 1'b1;
                or_idx_d   = mem_q[rd_ptr_q];
                or_taken_d = res_taken_i;
            end else if (or_vld_q && upd_ready_i) begin
                or_vld_d   = 1'b0;
            end
        end
    end

    // Control state; reset restarts the sweep and discards queue and output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            or_vld_q   <= 1'b0;
            or_idx_q   <= '0;
            or_taken_q <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            or_vld_q   <= or_vld_d;
            or_idx_q   <= or_idx_d;
            or_taken_q <= or_taken_d;
            res_err_q  <= res_err_d;
        end
    end

    // Queue storage holds only indices; entries are qualified by the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pred_pc_i[IDX_W-1:0];
        end
    end

endmodule

// File: tb/tb_lht_update_ctrl.sv
// Self-checking bench for lht_update_ctrl: vector table for queue/handshake behaviour,
// hand sequences for the sweep and resets, and a scoreboard of expected updates
// compared whenever the DUT hands an update to the table.
module tb_lht_update_ctrl;

    localparam int IDX_W = 10;
    localparam int DEPTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             pred_valid_i;
    logic [31:0]      pred_pc_i;
    logic             pred_ready_o;
    logic             res_valid_i;
    logic             res_taken_i;
    logic             res_ready_o;
    logic             res_err_o;
    logic             flush_i;
    logic             upd_valid_o;
    logic [IDX_W-1:0] upd_idx_o;
    logic             upd_taken_o;
    logic             upd_clear_o;
    logic             upd_ready_i;
    logic             busy_init_o;
    logic [3:0]       count_o;

    lht_update_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .pred_ready_o(pred_ready_o),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_ready_o(res_ready_o),
        .res_err_o(res_err_o), .flush_i(flush_i),
        .upd_valid_o(upd_valid_o), .upd_idx_o(upd_idx_o), .upd_taken_o(upd_taken_o),
        .upd_clear_o(upd_clear_o), .upd_ready_i(upd_ready_i),
        .busy_init_o(busy_init_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        rv;
        logic        rt;
        logic        fl;
        logic        ur;
        logic        e_prdy;
        logic        e_rrdy;
        logic [3:0]  e_cnt;
        logic        e_err;
        logic        e_uvld;
    } vec_t;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    vec_t             vq[$];
    upd_t             sb[$];
    logic [IDX_W-1:0] mq[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic void row(input logic pv, input logic [31:0] pc, input logic rv,
                                input logic rt, input logic fl, input logic ur,
                                input logic e_prdy, input logic e_rrdy, input logic [3:0] e_cnt,
                                input logic e_err, input logic e_uvld);
        vec_t v;
        v.pv = pv; v.pc = pc; v.rv = rv; v.rt = rt; v.fl = fl; v.ur = ur;
        v.e_prdy = e_prdy; v.e_rrdy = e_rrdy; v.e_cnt = e_cnt; v.e_err = e_err; v.e_uvld = e_uvld;
        vq.push_back(v);
    endfunction

    // Scoreboard drain: every non-clear update handed to the table must match the oldest expectation.
    always @(negedge clk_i) begin
        #2;
        if (!rst_i && upd_valid_o && upd_ready_i && !upd_clear_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_upd", {31'd0, upd_valid_o}, 32'd0);
            end else begin
                upd_t e;
                e = sb.pop_front();
                chk("drain_idx", {22'd0, upd_idx_o}, {22'd0, e.idx});
                chk("drain_taken", {31'd0, upd_taken_o}, {31'd0, e.taken});
            end
        end
    end

    // Full clear sweep starting at a negedge right after reset release.
    task automatic sweep(input bit stall);
        int errs;
        errs = 0;
        if (stall) begin
            upd_ready_i = 1'b0;
            repeat (3) begin
                @(posedge clk_i); @(negedge clk_i);
                if (upd_idx_o !== '0 || upd_valid_o !== 1'b1) errs++;
            end
            chk("init_stall_hold", errs, 0);
            upd_ready_i = 1'b1;
        end
        errs = 0;
        for (int i = 0; i < (1 << IDX_W); i++) begin
            if (upd_idx_o !== IDX_W'(i) || upd_valid_o !== 1'b1 ||
                upd_clear_o !== 1'b1 || busy_init_o !== 1'b1) errs++;
            @(posedge clk_i); @(negedge clk_i);
        end
        chk("sweep_sequence_errs", errs, 0);
        chk("sweep_busy_done", {31'd0, busy_init_o}, 32'd0);
        chk("sweep_upd_valid_done", {31'd0, upd_valid_o}, 32'd0);
        chk("sweep_clear_done", {31'd0, upd_clear_o}, 32'd0);
        chk("sweep_pred_ready", {31'd0, pred_ready_o}, 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; pred_valid_i = 1'b0; pred_pc_i = '0; res_valid_i = 1'b0;
        res_taken_i = 1'b0; flush_i = 1'b0; upd_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);

        // Reset values
        chk("rst_upd_valid", {31'd0, upd_valid_o}, 32'd1);
        chk("rst_upd_clear", {31'd0, upd_clear_o}, 32'd1);
        chk("rst_upd_idx", {22'd0, upd_idx_o}, 32'd0);
        chk("rst_upd_taken", {31'd0, upd_taken_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_init_o}, 32'd1);
        chk("rst_count", {28'd0, count_o}, 32'd0);
        chk("rst_pred_ready", {31'd0, pred_ready_o}, 32'd0);
        chk("rst_res_ready", {31'd0, res_ready_o}, 32'd0);
        chk("rst_res_err", {31'd0, res_err_o}, 32'd0);

        // Reset mid-sweep at index 500; traffic during INIT must be ignored.
        pred_valid_i = 1'b1; pred_pc_i = 32'h0000_0123; res_valid_i = 1'b1; flush_i = 1'b1;
        rst_i = 1'b0;
        repeat (500) begin @(posedge clk_i); @(negedge clk_i); end
        chk("midsweep_idx", {22'd0, upd_idx_o}, 32'd500);
        chk("init_count_ignored", {28'd0, count_o}, 32'd0);
        chk("init_pred_ready", {31'd0, pred_ready_o}, 32'd0);
        chk("init_res_ready", {31'd0, res_ready_o}, 32'd0);
        chk("init_res_err", {31'd0, res_err_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        chk("midsweep_rst_idx", {22'd0, upd_idx_o}, 32'd0);
        chk("midsweep_rst_busy", {31'd0, busy_init_o}, 32'd1);
        pred_valid_i = 1'b0; res_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        sweep(1'b1);

        //   pv  pc            rv rt fl ur | prdy rrdy cnt err uvld
        row(1, 32'h0000_04D2, 0, 0, 0, 1,   1, 0, 4'd1, 0, 0);
        row(1, 32'h0000_04D1, 0, 0, 0, 1,   1, 1, 4'd2, 0, 0);
        row(0, 32'h0,         1, 1, 0, 1,   1, 1, 4'd1, 0, 1);
        row(0, 32'h0,         1, 0, 0, 1,   1, 1, 4'd0, 0, 1);
        row(0, 32'h0,         0, 0, 0, 1,   1, 0, 4'd0, 0, 0);
        // Fill to DEPTH, refused 9th push, then pops with and without pushes.
        row(1, 32'h0000_0100, 0, 0, 0, 1,   1, 0, 4'd1, 0, 0);
        row(1, 32'h1234_5678, 0, 0, 0, 1,   1, 1, 4'd2, 0, 0);
        row(1, 32'hFFFF_FFFF, 0, 0, 0, 1,   1, 1, 4'd3, 0, 0);
        row(1, 32'h0000_0400, 0, 0, 0, 1,   1, 1, 4'd4, 0, 0);
        row(1, 32'h0000_03FF, 0, 0, 0, 1,   1, 1, 4'd5, 0, 0);
        row(1, 32'hABCD_E3C0, 0, 0, 0, 1,   1, 1, 4'd6, 0, 0);
        row(1, 32'h0000_0001, 0, 0, 0, 1,   1, 1, 4'd7, 0, 0);
        row(1, 32'h7FFF_0200, 0, 0, 0, 1,   1, 1, 4'd8, 0, 0);
        row(1, 32'hDEAD_0000, 0, 0, 0, 1,   0, 1, 4'd8, 0, 0);
        row(0, 32'h0,         1, 1, 0, 1,   0, 1, 4'd7, 0, 1);
        row(0, 32'h0,         0, 0, 0, 1,   1, 1, 4'd7, 0, 0);
        row(1, 32'h0000_0555, 1, 0, 0, 1,   1, 1, 4'd7, 0, 1);
        row(1, 32'h0000_0666, 0, 0, 0, 1,   1, 1, 4'd8, 0, 0);
        row(1, 32'h0000_0777, 1, 1, 0, 1,   0, 1, 4'd7, 0, 1);
        for (int k = 0; k < 7; k++)
            row(0, 32'h0, 1, 1'(k % 2), 0, 1, 1, 1, 4'(6 - k), 0, 1);
        row(0, 32'h0,         0, 0, 0, 1,   1, 0, 4'd0, 0, 0);
        // Output register stalled by upd_ready, then released.
        row(1, 32'h0000_ABC1, 0, 0, 0, 0,   1, 0, 4'd1, 0, 0);
        row(1, 32'h0000_ABC2, 0, 0, 0, 0,   1, 1, 4'd2, 0, 0);
        row(0, 32'h0,         1, 1, 0, 0,   1, 1, 4'd1, 0, 1);
        row(0, 32'h0,         1, 0, 0, 0,   1, 0, 4'd1, 0, 1);
        row(0, 32'h0,         1, 0, 0, 1,   1, 1, 4'd0, 0, 1);
        row(0, 32'h0,         0, 0, 0, 1,   1, 0, 4'd0, 0, 0);
        // Flush with same-cycle resolution and push, then resolution on empty queue.
        row(1, 32'h0000_0011, 0, 0, 0, 1,   1, 0, 4'd1, 0, 0);
        row(1, 32'h0000_0022, 0, 0, 0, 1,   1, 1, 4'd2, 0, 0);
        row(1, 32'h0000_0033, 0, 0, 0, 1,   1, 1, 4'd3, 0, 0);
        row(1, 32'h0000_0044, 1, 1, 1, 1,   1, 1, 4'd0, 0, 1);
        row(0, 32'h0,         1, 0, 0, 1,   1, 0, 4'd0, 1, 0);
        row(0, 32'h0,         0, 0, 0, 1,   1, 0, 4'd0, 0, 0);

        foreach (vq[k]) begin
            vec_t v;
            logic acc;
            logic [IDX_W-1:0] exp_idx;
            v = vq[k];
            pred_valid_i = v.pv; pred_pc_i = v.pc; res_valid_i = v.rv;
            res_taken_i = v.rt; flush_i = v.fl; upd_ready_i = v.ur;
            #1;
            chk($sformatf("row%0d_pred_ready", k), {31'd0, pred_ready_o}, {31'd0, v.e_prdy});
            chk($sformatf("row%0d_res_ready", k), {31'd0, res_ready_o}, {31'd0, v.e_rrdy});
            acc = v.rv && v.e_rrdy;
            exp_idx = '0;
            if (acc && mq.size() > 0) exp_idx = mq.pop_front();
            if (v.fl) mq.delete();
            else if (v.pv && v.e_prdy) mq.push_back(v.pc[IDX_W-1:0]);
            @(posedge clk_i);
            #1;
            chk($sformatf("row%0d_count", k), {28'd0, count_o}, {28'd0, v.e_cnt});
            chk($sformatf("row%0d_res_err", k), {31'd0, res_err_o}, {31'd0, v.e_err});
            chk($sformatf("row%0d_upd_valid", k), {31'd0, upd_valid_o}, {31'd0, v.e_uvld});
            if (acc) begin
                upd_t u;
                chk($sformatf("row%0d_upd_idx", k), {22'd0, upd_idx_o}, {22'd0, exp_idx});
                chk($sformatf("row%0d_upd_taken", k), {31'd0, upd_taken_o}, {31'd0, v.rt});
                u.idx = exp_idx; u.taken = v.rt;
                sb.push_back(u);
            end
            @(negedge clk_i);
        end
        pred_valid_i = 1'b0; res_valid_i = 1'b0; flush_i = 1'b0; upd_ready_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        chk("sb_empty_after_table", sb.size(), 0);

        // Reset during RUN with 4 queued entries.
        for (int i = 0; i < 4; i++) begin
            pred_valid_i = 1'b1; pred_pc_i = 32'h0000_0200 + 32'(i);
            @(posedge clk_i); @(negedge clk_i);
        end
        pred_valid_i = 1'b0;
        #1;
        chk("run_queued4", {28'd0, count_o}, 32'd4);
        rst_i = 1'b1;
        #1;
        chk("run_rst_count", {28'd0, count_o}, 32'd0);
        chk("run_rst_busy", {31'd0, busy_init_o}, 32'd1);
        chk("run_rst_idx", {22'd0, upd_idx_o}, 32'd0);
        chk("run_rst_clear", {31'd0, upd_clear_o}, 32'd1);
        chk("run_rst_pred_ready", {31'd0, pred_ready_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        sweep(1'b0);
        chk("sb_empty_final", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
